// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue/response sequencer: select codes,
// ALUOp/funct3 decode constants, FSM states and the internal operation set.
package alu_pkg;

  localparam logic [3:0] ALU_SEL_AND = 4'b0000;
  localparam logic [3:0] ALU_SEL_OR  = 4'b0001;
  localparam logic [3:0] ALU_SEL_ADD = 4'b0010;
  localparam logic [3:0] ALU_SEL_SUB = 4'b0110;
  // The ALU answers 0 for these two codes, so they are never issued.
  localparam logic [3:0] ALU_SEL_SLT = 4'b0111;
  localparam logic [3:0] ALU_SEL_NOR = 4'b1100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_NOR   = 2'b11;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_FIX,
    ST_RESP
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_SLT,
    OP_NOR,
    OP_ILL
  } op_e;

endpackage

// File: rtl/alu_decode.sv
// Maps ALUOp/funct3/funct7[5] to an internal operation, the select code the
// ALU is driven with, and whether a fix-up step follows the ALU pass.
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output op_e        op,
  output logic [3:0] sel,
  output logic       two_step
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    op = OP_ILL;
    case (aluop)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_NOR: op = OP_NOR;
      default: begin
        case (funct3)
          F3_ADD_SUB: op = funct7_5 ? OP_SUB : OP_ADD;
          F3_SLT:     op = OP_SLT;
          F3_OR:      op = OP_OR;
          F3_AND:     op = OP_AND;
          default:    op = OP_ILL;
        endcase
      end
    endcase
  end

  // SLT runs as a subtract and NOR as an OR; the fix-up finishes them.
  always_comb begin
    sel      = ALU_SEL_AND;
    two_step = 1'b0;
    case (op)
      OP_ADD: sel = ALU_SEL_ADD;
      OP_SUB: sel = ALU_SEL_SUB;
      OP_AND: sel = ALU_SEL_AND;
      OP_OR:  sel = ALU_SEL_OR;
      OP_SLT: begin
        sel      = ALU_SEL_SUB;
        two_step = 1'b1;
      end
      OP_NOR: begin
        sel      = ALU_SEL_OR;
        two_step = 1'b1;
      end
      default: sel = ALU_SEL_AND;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Registered issue/response front end for the external combinational ALU:
// one request in flight, optional fix-up pass for SLT and NOR.
module alu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_aluop,
  input  logic [2:0]      req_funct3,
  input  logic            req_funct7_5,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  output logic [XLEN-1:0] alu_rs1_data,
  output logic [XLEN-1:0] alu_rs2_data,
  output logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] alu_out,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_zero,
  output logic            rsp_illegal
);
  import alu_pkg::*;

  state_e          state_q, state_d;
  op_e             dec_op, op_q;
  logic [3:0]      dec_sel, sel_q;
  logic            dec_two_step, two_step_q;
  logic [XLEN-1:0] rs1_q, rs2_q, cap_q;
  logic [XLEN-1:0] fix_result;
  logic            slt_bit;

  alu_decode u_decode (
    .aluop    (req_aluop),
    .funct3   (req_funct3),
    .funct7_5 (req_funct7_5),
    .op       (dec_op),
    .sel      (dec_sel),
    .two_step (dec_two_step)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    alu_sel      = ALU_SEL_AND;
    alu_rs1_data = '0;
    alu_rs2_data = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = !rst;
        if (req_valid) state_d = (dec_op == OP_ILL) ? ST_RESP : ST_EXEC;
      end
      ST_EXEC: begin
        alu_sel      = sel_q;
        alu_rs1_data = rs1_q;
        alu_rs2_data = rs2_q;
        state_d      = two_step_q ? ST_FIX : ST_RESP;
      end
      ST_FIX:  state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sign-differing operands make the wrapped difference unreliable; rs1's sign decides.
  assign slt_bit    = (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]) ? rs1_q[XLEN-1] : cap_q[XLEN-1];
  assign fix_result = (op_q == OP_SLT) ? {{(XLEN-1){1'b0}}, slt_bit} : ~cap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= OP_ADD;
      sel_q       <= ALU_SEL_AND;
      two_step_q  <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      cap_q       <= '0;
      rsp_data    <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q       <= dec_op;
            sel_q      <= dec_sel;
            two_step_q <= dec_two_step;
            rs1_q      <= req_rs1;
            rs2_q      <= req_rs2;
            if (dec_op == OP_ILL) begin
              rsp_data    <= '0;
              rsp_zero    <= 1'b1;
              rsp_illegal <= 1'b1;
            end else begin
              rsp_illegal <= 1'b0;
            end
          end
        end
        ST_EXEC: begin
          if (two_step_q) begin
            cap_q <= alu_out;
          end else begin
            rsp_data <= alu_out;
            rsp_zero <= (alu_out == '0);
          end
        end
        ST_FIX: begin
          rsp_data <= fix_result;
          rsp_zero <= (fix_result == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Registered issue/response front end for the combinational `alu` in the RISC-V datapath. It accepts an operation request over a valid/ready handshake and decodes ALUOp/funct3/funct7 into an `aluSel` code. It drives the ALU's operand and select inputs, then captures the result. SLT and NOR are synthesised as two-step sequences (SUB + sign fix-up, OR + invert) because the ALU returns 0 for those select codes.

## Interface
Parameters:
- `XLEN`, 32, operand/result width (only 32 supported)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  sequencer can accept
- `req_aluop`  in  2  00 ADD, 01 SUB, 10 R-type decode, 11 NOR
- `req_funct3`  in  3  R-type funct3
- `req_funct7_5`  in  1  funct7 bit 5
- `req_rs1`, `req_rs2`  in  32  operands
- `alu_rs1_data`, `alu_rs2_data`  out  32  to ALU
- `alu_sel`  out  4  to ALU `aluSel`
- `alu_out`  in  32  from ALU
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts
- `rsp_data`  out  32  result
- `rsp_zero`  out  1  `rsp_data == 0`
- `rsp_illegal`  out  1  undecodable request

## Operation
- Select codes: AND 0000, OR 0001, ADD 0010, SUB 0110.
- R-type decode (aluop 10):
  - funct3 000/f7=0 → ADD
  - 000/f7=1 → SUB
  - 111 → AND
  - 110 → OR
  - 010 → SLT
  - any other combination → illegal
- FSM states: IDLE, EXEC, FIX, RESP.
  - IDLE: `req_ready`=1. On `req_valid`, latch operands and decoded op. Legal → EXEC; illegal → RESP with `rsp_data`=0, `rsp_illegal`=1.
  - EXEC: drive latched operands and selected code (SLT issues SUB, NOR issues OR). Capture `alu_out` at the clock edge. Simple ops → RESP; SLT/NOR → FIX.
  - FIX, for SLT: result = {31'b0, (rs1[31]^rs2[31]) ? rs1[31] : diff[31]}, which is overflow-correct signed compare.
  - FIX, for NOR: result = ~captured value. Next state is RESP.
  - RESP: `rsp_valid`=1. Data and flags are stable until `rsp_valid && rsp_ready`, then → IDLE.
- `rsp_zero` is computed from the final result in the same cycle it is registered.
- `alu_sel`=0000 and ALU operands = 0 in every state except EXEC.
- Arithmetic wraps modulo 2^32, with no overflow output.

## Timing
- Reset (`rst` high at an edge) → IDLE. Outputs after reset:
  - `rsp_valid`, `rsp_data`, `rsp_zero`, `rsp_illegal` = 0
  - `req_ready`=1 from the first cycle after reset deassert
  - `req_ready`=0 while `rst` is high
- Accept edge = cycle 0.
- Simple op: EXEC in cycle 1; `rsp_valid` from cycle 2.
- SLT/NOR: EXEC cycle 1, FIX cycle 2; `rsp_valid` from cycle 3.
- Illegal: `rsp_valid` from cycle 1.
- One request in flight. `req_ready`=0 from EXEC until the cycle after the response handshake. Minimum 3-cycle initiation interval for simple ops.
- `rsp_ready` held low: remain in RESP indefinitely, with outputs frozen.
- Reset mid-operation: in-flight request dropped, no response emitted.
- `req_valid` while not ready: ignored. The requester holds the request.

## Structure
- Package `alu_pkg`:
  - aluSel localparams (AND/OR/ADD/SUB/SLT/NOR)
  - ALUOp encodings
  - funct3 constants
  - FSM state encoding
  - internal op enum (ADD, SUB, AND, OR, SLT, NOR, ILL)
- Sub-module `alu_decode`: combinational mapping of aluop/funct3/funct7_5 to internal op, aluSel, and a two-step flag.
- The existing `alu` is instantiated beside this block by the datapath top, not inside it.

## Test plan
- Reset, then ADD request (aluop 00, rs1=0x00000005, rs2=0x00000003) with `rsp_ready`=1.
  - Required: `rsp_valid` in cycle 2, `rsp_data`=0x00000008, `rsp_zero`=0.
- SUB via R-type (funct3 000, f7=1, rs1=rs2=0x12345678).
  - Required: `rsp_data`=0, `rsp_zero`=1, `alu_sel`=0110 during EXEC.
- SLT overflow case (funct3 010, rs1=0x80000000, rs2=0x00000001).
  - Required: response in cycle 3 with `rsp_data`=0x00000001.
  - Also rs1=0x00000001, rs2=0xFFFFFFFF → 0x00000000.
- NOR (aluop 11, rs1=0xF0F0F0F0, rs2=0x0F0F0000).
  - Required: `rsp_data`=0x00000F0F, with `alu_sel`=0001 in EXEC.
- Illegal R-type (funct3 001).
  - Required: `rsp_valid` in cycle 1, `rsp_illegal`=1, `rsp_data`=0, ALU select stays 0000.
- Backpressure and reset abort.
  - `rsp_ready`=0 for 5 cycles: response held constant and `req_ready`=0 throughout.
  - Assert `rst` during EXEC: no `rsp_valid`, IDLE next cycle.
